// File: rtl/tournament_selection.sv
// GA parent selection: holds the population and runs two binary tournaments per
// start, picking candidates from a free-running Galois LFSR.
module tournament_selection #(
    parameter int          CHROM_WIDTH = 8,
    parameter int          FIT_WIDTH   = 8,
    parameter int          POP_SIZE    = 16,
    parameter int          IDX_WIDTH   = $clog2(POP_SIZE),
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [IDX_WIDTH-1:0]   load_idx,
    input  logic [CHROM_WIDTH-1:0] load_chrom,
    input  logic [FIT_WIDTH-1:0]   load_fit,
    input  logic                   start,
    output logic                   busy,
    output logic                   parents_valid,
    output logic [CHROM_WIDTH-1:0] parent1,
    output logic [CHROM_WIDTH-1:0] parent2
);

    // An all-zero Galois state would lock up, so a zero seed is remapped.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [2:0] {IDLE, T1A, T1B, T2A, T2B, OUT} state_t;

    state_t                 state, state_nxt;
    logic [15:0]            lfsr;
    logic [CHROM_WIDTH-1:0] chrom [POP_SIZE];
    logic [FIT_WIDTH-1:0]   fit   [POP_SIZE];
    logic [IDX_WIDTH-1:0]   cand, a_idx, w1, w_cur;

    assign cand  = lfsr[IDX_WIDTH-1:0];
    // Shared compare for both tournaments; ties keep the first candidate.
    assign w_cur = (fit[cand] > fit[a_idx]) ? cand : a_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= SEED;
        else     lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < POP_SIZE; i++) begin
                chrom[i] <= '0;
                fit[i]   <= '0;
            end
        end else if (load_en && state == IDLE) begin
            chrom[load_idx] <= load_chrom;
            fit[load_idx]   <= load_fit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_idx   <= '0;
            w1      <= '0;
            parent1 <= '0;
            parent2 <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                T1A, T2A: a_idx <= cand;
                T1B:      w1    <= w_cur;
                T2B: if (w_cur != w1) begin
                    parent1 <= chrom[w1];
                    parent2 <= chrom[w_cur];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = T1A;
            T1A:     state_nxt = T1B;
            T1B:     state_nxt = T2A;
            T2A:     state_nxt = T2B;
            T2B:     state_nxt = (w_cur == w1) ? T2A : OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy          = (state != IDLE);
    assign parents_valid = (state == OUT);

endmodule

// File: tb/tb_tournament_selection.sv
// Directed bench for tournament_selection: a default instance and a POP_SIZE=2
// instance share clock/reset; expectations come from a tournament reference model.
module tb_tournament_selection;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       load_en_a = 0, start_a = 0;
    logic [3:0] load_idx_a = '0;
    logic [7:0] load_chrom_a = '0, load_fit_a = '0;
    logic       busy_a, pv_a;
    logic [7:0] p1_a, p2_a;

    logic       load_en_b = 0, start_b = 0;
    logic [0:0] load_idx_b = '0;
    logic [7:0] load_chrom_b = '0, load_fit_b = '0;
    logic       busy_b, pv_b;
    logic [7:0] p1_b, p2_b;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mchrom_a [16];
    logic [7:0]  mfit_a   [16];
    logic [7:0]  mchrom_b [2];
    logic [7:0]  mfit_b   [2];
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    tournament_selection u_a (
        .clk(clk), .rst(rst), .load_en(load_en_a), .load_idx(load_idx_a),
        .load_chrom(load_chrom_a), .load_fit(load_fit_a), .start(start_a),
        .busy(busy_a), .parents_valid(pv_a), .parent1(p1_a), .parent2(p2_a)
    );

    tournament_selection #(.POP_SIZE(2)) u_b (
        .clk(clk), .rst(rst), .load_en(load_en_b), .load_idx(load_idx_b),
        .load_chrom(load_chrom_b), .load_fit(load_fit_b), .start(start_b),
        .busy(busy_b), .parents_valid(pv_b), .parent1(p1_b), .parent2(p2_b)
    );

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= lstep(m_lfsr);
    end

    function automatic int cidx(input int which, input logic [15:0] l);
        return (which != 0) ? int'(l[0]) : int'(l[3:0]);
    endfunction

    function automatic logic [7:0] mfit(input int which, input int i);
        return (which != 0) ? mfit_b[i] : mfit_a[i];
    endfunction

    function automatic logic [7:0] mchrom(input int which, input int i);
        return (which != 0) ? mchrom_b[i] : mchrom_a[i];
    endfunction

    // l0 is the LFSR value during the T1A cycle; each later state takes the next value.
    task automatic predict(input int which, input logic [15:0] l0,
                           output int retries, output logic [7:0] e1, output logic [7:0] e2);
        logic [15:0] l;
        int a, b, w1, w2;
        l = l0;
        a = cidx(which, l);
        l = lstep(l);
        b = cidx(which, l);
        w1 = (mfit(which, b) > mfit(which, a)) ? b : a;
        retries = 0;
        forever begin
            l = lstep(l);
            a = cidx(which, l);
            l = lstep(l);
            b = cidx(which, l);
            w2 = (mfit(which, b) > mfit(which, a)) ? b : a;
            if (w2 != w1 || retries > 200) break;
            retries++;
        end
        e1 = mchrom(which, w1);
        e2 = mchrom(which, w2);
    endtask

    task automatic clear_models();
        for (int i = 0; i < 16; i++) begin mchrom_a[i] = '0; mfit_a[i] = '0; end
        for (int i = 0; i < 2; i++) begin mchrom_b[i] = '0; mfit_b[i] = '0; end
    endtask

    task automatic load_a(input int idx, input logic [7:0] c, input logic [7:0] f);
        load_en_a = 1; load_idx_a = 4'(idx); load_chrom_a = c; load_fit_a = f;
        @(posedge clk); @(negedge clk);
        load_en_a = 0;
        mchrom_a[idx] = c; mfit_a[idx] = f;
    endtask

    task automatic load_b(input int idx, input logic [7:0] c, input logic [7:0] f);
        load_en_b = 1; load_idx_b = 1'(idx); load_chrom_b = c; load_fit_b = f;
        @(posedge clk); @(negedge clk);
        load_en_b = 0;
        mchrom_b[idx] = c; mfit_b[idx] = f;
    endtask

    // Called at a negedge while idle; optionally injects start+load during T1B.
    task automatic run(input int which, input bit inject, input string tag,
                       output logic [7:0] g1, output logic [7:0] g2);
        int r, got;
        logic [7:0] e1, e2;
        logic pv, bz;
        predict(which, lstep(m_lfsr), r, e1, e2);
        if (which != 0) start_b = 1; else start_a = 1;
        @(posedge clk); @(negedge clk);
        start_a = 0; start_b = 0;
        got = 0;
        for (int k = 1; k <= 80; k++) begin
            if (k > 1) @(negedge clk);
            pv = (which != 0) ? pv_b : pv_a;
            bz = (which != 0) ? busy_b : busy_a;
            if (k == 1) begin
                checks++;
                if (bz !== 1'b1) begin
                    errors++; $display("FAIL %s busy_after_start got %b want 1", tag, bz);
                end
            end
            if (inject && k == 2) begin
                start_a = 1; load_en_a = 1; load_idx_a = 4'd3; load_chrom_a = 8'hFF; load_fit_a = 8'hFF;
            end
            if (inject && k == 3) begin start_a = 0; load_en_a = 0; end
            if (pv === 1'b1) begin got = k; break; end
        end
        g1 = (which != 0) ? p1_b : p1_a;
        g2 = (which != 0) ? p2_b : p2_a;
        checks++;
        if (got != 5 + 2 * r) begin
            errors++; $display("FAIL %s valid_cycle got %0d want %0d", tag, got, 5 + 2 * r);
        end
        checks++;
        if (g1 !== e1 || g2 !== e2) begin
            errors++; $display("FAIL %s parents got %h/%h want %h/%h", tag, g1, g2, e1, e2);
        end
        @(negedge clk);
        pv = (which != 0) ? pv_b : pv_a;
        bz = (which != 0) ? busy_b : busy_a;
        checks++;
        if (pv !== 1'b0 || bz !== 1'b0) begin
            errors++; $display("FAIL %s after_out valid=%b busy=%b want 0/0", tag, pv, bz);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy_a, pv_a, p1_a, p2_a} !== 18'h0) begin
            errors++; $display("FAIL reset_a got busy=%b pv=%b p1=%h p2=%h want 0", busy_a, pv_a, p1_a, p2_a);
        end
        checks++;
        if ({busy_b, pv_b, p1_b, p2_b} !== 18'h0) begin
            errors++; $display("FAIL reset_b got busy=%b pv=%b p1=%h p2=%h want 0", busy_b, pv_b, p1_b, p2_b);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_uniform();
        logic [7:0] g1, g2;
        for (int i = 0; i < 16; i++) load_a(i, 8'h3C, 8'h10);
        for (int n = 0; n < 8; n++) begin
            run(0, 0, "uniform", g1, g2);
            checks++;
            if (g1 !== 8'h3C || g2 !== 8'h3C) begin
                errors++; $display("FAIL uniform_value got %h/%h want 3c/3c", g1, g2);
            end
        end
    endtask

    task automatic test_pop2();
        logic [7:0] g1, g2;
        load_b(0, 8'h11, 8'd10);
        load_b(1, 8'h22, 8'd20);
        for (int n = 0; n < 50; n++) begin
            run(1, 0, "pop2", g1, g2);
            checks++;
            if (!((g1 === 8'h11 && g2 === 8'h22) || (g1 === 8'h22 && g2 === 8'h11))) begin
                errors++; $display("FAIL pop2_pair got %h/%h want {11,22}", g1, g2);
            end
        end
    endtask

    task automatic test_graded();
        logic [7:0] g1, g2;
        for (int i = 0; i < 16; i++) load_a(i, 8'hA0 + 8'(i), 8'(i));
        for (int n = 0; n < 1000; n++) run(0, 0, "graded", g1, g2);
    endtask

    task automatic test_busy_filter();
        logic [7:0] g1, g2;
        run(0, 1, "busy_filter", g1, g2);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (pv_a !== 1'b0) begin
                errors++; $display("FAIL busy_filter_extra_valid got %b want 0", pv_a);
            end
        end
        for (int n = 0; n < 20; n++) begin
            run(0, 0, "post_filter", g1, g2);
            checks++;
            if (g1 === 8'hFF || g2 === 8'hFF) begin
                errors++; $display("FAIL post_filter_ff got %h/%h want not ff", g1, g2);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] g1, g2;
        start_a = 1;
        @(posedge clk); @(negedge clk);
        start_a = 0;
        #2 rst = 1;
        #1;
        checks++;
        if ({busy_a, pv_a, p1_a, p2_a} !== 18'h0) begin
            errors++; $display("FAIL async_reset got busy=%b pv=%b p1=%h p2=%h want 0", busy_a, pv_a, p1_a, p2_a);
        end
        clear_models();
        @(negedge clk);
        rst = 0;
        run(0, 0, "after_reset", g1, g2);
    endtask

    task automatic test_abort();
        logic [7:0] g1, g2;
        for (int i = 0; i < 16; i++) load_a(i, 8'hA0 + 8'(i), 8'(i));
        start_a = 1;
        @(posedge clk); @(negedge clk);
        start_a = 0;
        @(negedge clk); @(negedge clk);
        #1 rst = 1;
        #1;
        checks++;
        if ({busy_a, p1_a, p2_a} !== 17'h0) begin
            errors++; $display("FAIL abort_outputs got busy=%b p1=%h p2=%h want 0", busy_a, p1_a, p2_a);
        end
        clear_models();
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (pv_a !== 1'b0) begin
                errors++; $display("FAIL abort_valid got %b want 0", pv_a);
            end
        end
        for (int n = 0; n < 4; n++) begin
            run(0, 0, "abort_zero_pop", g1, g2);
            checks++;
            if (g1 !== 8'h00 || g2 !== 8'h00) begin
                errors++; $display("FAIL abort_pop got %h/%h want 00/00", g1, g2);
            end
        end
    endtask

    initial begin
        clear_models();
        test_reset();
        test_uniform();
        test_pop2();
        test_graded();
        test_busy_filter();
        test_async_reset();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
